line_writer: RTL and testbench

LINE_WRITER -- requirements
Module: line_writer

---
 rtl/line_writer.sv | 120 ++++++++++++
 tb/tb_line_writer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/line_writer.sv
// Line writer: packs accepted char-pair beats into char memory and commits one
// {len, start} pointer entry per line. Define LINE_WRITER_OVERFLOW_EN for sticky overflow on exhaustion.
module line_writer #(
  parameter int unsigned LINES   = 16,
  parameter logic [7:0]  MEM_TOP = 8'hFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_lhs,
  input  logic [7:0]  in_rhs,
  input  logic        in_last,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        ptr_we,
  output logic [7:0]  ptr_addr,
  output logic [15:0] ptr_din,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} state_t;

  state_t state, state_nx;

`ifdef LINE_WRITER_OVERFLOW_EN
  // Extra bit lets the free pointer sit one past MEM_TOP to mark exhaustion.
  logic [8:0] free, free_nx;
`else
  logic [7:0] free, free_nx;
`endif
  logic [7:0] start, start_nx;
  logic [7:0] len, len_nx;
  logic [7:0] line;
  logic       accept;
  logic       room;
  logic       last_beat;

  always_comb begin
    in_ready = (state == IDLE) || (state == FILL);
    done     = (state == DONE);
    accept   = in_valid && in_ready;
`ifdef LINE_WRITER_OVERFLOW_EN
    room     = (free <= {1'b0, MEM_TOP});
    free_nx  = room ? free + 9'd1 : free;
`else
    room     = 1'b1;
    free_nx  = (free == MEM_TOP) ? '0 : free + 8'd1;
`endif
    start_nx  = (state == IDLE) ? free[7:0] : start;
    len_nx    = room ? len + 8'd1 : len;
    last_beat = in_last || (len_nx == 8'hFF);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FILL: if (accept) state_nx = last_beat ? COMMIT : FILL;
      COMMIT:     state_nx = ({1'b0, line} + 9'd1 == 9'(LINES)) ? DONE : IDLE;
      DONE:       state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Pointer entry is registered at the last beat's acceptance so ptr_we lands
  // in the COMMIT cycle alongside that beat's mem_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free     <= '0;
      start    <= '0;
      len      <= '0;
      line     <= '0;
      mem_we   <= 1'b0;
      mem_addr <= 8'hFF;
      mem_din  <= '0;
      ptr_we   <= 1'b0;
      ptr_addr <= '0;
      ptr_din  <= '0;
    end else begin
      mem_we <= 1'b0;
      ptr_we <= 1'b0;
      if (accept) begin
        start <= start_nx;
        len   <= len_nx;
        if (room) begin
          mem_we   <= 1'b1;
          mem_addr <= free[7:0];
          mem_din  <= {in_lhs, in_rhs};
          free     <= free_nx;
        end
        if (last_beat) begin
          ptr_we   <= 1'b1;
          ptr_addr <= line;
          ptr_din  <= {len_nx, start_nx};
        end
      end
      if (state == COMMIT) begin
        line <= line + 8'd1;
        len  <= '0;
      end
    end
  end

`ifdef LINE_WRITER_OVERFLOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  overflow <= 1'b0;
    else if (accept && !room) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_line_writer.sv
// Directed bench for line_writer (default build) with LINES=3, MEM_TOP=8'h03.
module tb_line_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_lhs = '0;
  logic [7:0]  in_rhs = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        ptr_we;
  logic [7:0]  ptr_addr;
  logic [15:0] ptr_din;
  logic        done;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  line_writer #(.LINES(3), .MEM_TOP(8'h03)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .ptr_we(ptr_we), .ptr_addr(ptr_addr), .ptr_din(ptr_din),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] l, input logic [7:0] r, input logic last);
    in_valid = 1'b1;
    in_lhs   = l;
    in_rhs   = r;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input logic [7:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 16'(mem_we), 16'h1);
    chk({tag, "_addr"}, 16'(mem_addr), 16'(a));
    chk({tag, "_din"}, mem_din, d);
  endtask

  task automatic chk_ptr(input string tag, input logic [7:0] a, input logic [15:0] d);
    chk({tag, "_pwe"}, 16'(ptr_we), 16'h1);
    chk({tag, "_paddr"}, 16'(ptr_addr), 16'(a));
    chk({tag, "_pdin"}, ptr_din, d);
    chk({tag, "_ready"}, 16'(in_ready), 16'h0);
  endtask

  initial begin
    logic [7:0] i8;

    // reset values while rst is high
    tick();
    tick();
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", 16'(mem_addr), 16'h00FF);
    chk("rst_mem_din", mem_din, 16'h0000);
    chk("rst_ptr_we", 16'(ptr_we), 16'h0);
    chk("rst_ptr_addr", 16'(ptr_addr), 16'h0000);
    chk("rst_ptr_din", ptr_din, 16'h0000);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    chk("rst_ready", 16'(in_ready), 16'h1);
    rst = 1'b0;
    tick();
    chk("hold_mem_addr", 16'(mem_addr), 16'h00FF);

    // two-beat line
    beat(8'h41, 8'h61, 1'b0);
    chk_mem("l0b0", 8'h00, 16'h4161);
    chk("l0b0_pwe", 16'(ptr_we), 16'h0);
    beat(8'h42, 8'h62, 1'b1);
    chk_mem("l0b1", 8'h01, 16'h4262);
    chk_ptr("l0", 8'h00, 16'h0200);
    tick();
    chk("idle_mem_we", 16'(mem_we), 16'h0);
    chk("idle_ptr_we", 16'(ptr_we), 16'h0);
    chk("idle_hold_addr", 16'(mem_addr), 16'h0001);
    chk("idle_hold_pdin", ptr_din, 16'h0200);
    chk("idle_ready", 16'(in_ready), 16'h1);

    // reset, then lines of 3 and 1 beats; free pointer wraps after 03
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i8 = 8'(i);
      beat(8'h30 + i8, 8'h50 + i8, i == 2);
      chk_mem("la", i8, {8'h30 + i8, 8'h50 + i8});
    end
    chk_ptr("la", 8'h00, 16'h0300);
    tick();
    beat(8'h7A, 8'h5A, 1'b1);
    chk_mem("lb", 8'h03, 16'h7A5A);
    chk_ptr("lb", 8'h01, 16'h0103);
    tick();

    // six-beat line wraps through MEM_TOP; last line of three -> DONE
    for (int i = 0; i < 6; i++) begin
      i8 = 8'(i);
      beat(i8, ~i8, i == 5);
      chk_mem("wrap", 8'(i % 4), {i8, ~i8});
      chk("wrap_ovf", 16'(overflow), 16'h0);
    end
    chk_ptr("wrap", 8'h02, 16'h0600);
    tick();
    chk("done_flag", 16'(done), 16'h1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_no_we", 16'(mem_we), 16'h0);
      chk("done_no_pwe", 16'(ptr_we), 16'h0);
      chk("done_ready", 16'(in_ready), 16'h0);
      chk("done_hold", 16'(done), 16'h1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // reset abandons a half-written line
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat(8'h11, 8'h21, 1'b0);
    chk_mem("ab0", 8'h00, 16'h1121);
    beat(8'h12, 8'h22, 1'b0);
    chk_mem("ab1", 8'h01, 16'h1222);
    #2 rst = 1'b1;
    #1;
    chk("ab_rst_addr", 16'(mem_addr), 16'h00FF);
    chk("ab_rst_we", 16'(mem_we), 16'h0);
    chk("ab_rst_pwe", 16'(ptr_we), 16'h0);
    #1 rst = 1'b0;
    tick();
    chk("ab_idle_pwe", 16'(ptr_we), 16'h0);
    chk("ab_idle_addr", 16'(mem_addr), 16'h00FF);
    chk("ab_idle_done", 16'(done), 16'h0);
    beat(8'h13, 8'h23, 1'b1);
    chk_mem("ab_new", 8'h00, 16'h1323);
    chk_ptr("ab_new", 8'h00, 16'h0100);
    tick();

    // in_valid gap mid-line
    beat(8'h44, 8'h64, 1'b0);
    chk_mem("gap0", 8'h01, 16'h4464);
    tick();
    chk("gap_we", 16'(mem_we), 16'h0);
    chk("gap_ready", 16'(in_ready), 16'h1);
    tick();
    beat(8'h45, 8'h65, 1'b1);
    chk_mem("gap1", 8'h02, 16'h4565);
    chk_ptr("gap", 8'h01, 16'h0201);
    tick();

    // 255 beats without last auto-commit with len = FF
    for (int i = 0; i < 255; i++) begin
      i8 = 8'(i);
      beat(i8, ~i8, 1'b0);
      chk_mem("long", 8'((3 + i) % 4), {i8, ~i8});
      if (i < 254) chk("long_pwe", 16'(ptr_we), 16'h0);
    end
    chk_ptr("long", 8'h02, 16'hFF03);
    tick();
    chk("long_done", 16'(done), 16'h1);
    chk("long_ovf", 16'(overflow), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
